// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash target: decodes 0B/02/05 and serves them from a 32-bit memory port.
// SPI pins are oversampled in the clk domain, so SCK must be at most clk/8.
module spi_flash_responder #(
    parameter int          MEM_W       = 32,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_cs_n,
    input  logic               spi_sck,
    input  logic               spi_mosi,
    output logic               spi_miso,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [MEM_W-1:0]   mem_wdata,
    output logic [MEM_W/8-1:0] mem_be,
    input  logic [MEM_W-1:0]   mem_rdata,
    input  logic               mem_valid,
    output logic               busy,
    output logic               err
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RD, WR, STAT, IGNORE} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic             cs_s, sck_s, mosi_s, cs_d, sck_d;
    logic             sck_rise, sck_fall, cs_rise, cs_fall;
    logic             byte_done, addr_done, last_rise;
    logic [4:0]       cnt;
    logic [22:0]      shreg;
    logic [7:0]       rx_byte, opcode, lane_byte, load_byte, tx_sr;
    logic [23:0]      rx_addr, addr, addr_inc;
    logic [MEM_W-1:0] cur_word, pf_word;
    logic             want_fetch, want_pf, req_pf, req_live;
    logic [31:0]      want_addr;

    function automatic logic [31:0] word_addr(input logic [23:0] a);
        logic [31:0] s;
        s = ADDR_BASE + {8'h00, a[23:2], 2'b00};
        return {s[31:2], 2'b00};
    endfunction

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_d & ~cs_s;
    assign sck_fall  = ~sck_s & sck_d & ~cs_s;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign rx_byte   = {shreg[6:0], mosi_s};
    assign rx_addr   = {shreg, mosi_s};
    assign last_rise = (state == ADDR) ? (cnt == 5'd23) : (cnt == 5'd7);
    assign byte_done = sck_rise && (cnt == 5'd7);
    assign addr_done = sck_rise && (cnt == 5'd23);
    assign addr_inc  = addr + 24'd1;
    assign busy      = ~cs_s | mem_req;

    always_comb begin
        lane_byte = cur_word[7:0];
        case (addr[1:0])
            2'd1:    lane_byte = cur_word[15:8];
            2'd2:    lane_byte = cur_word[23:16];
            2'd3:    lane_byte = cur_word[31:24];
            default: lane_byte = cur_word[7:0];
        endcase
        load_byte = (state == STAT) ? {6'b0, err, mem_req} : lane_byte;
    end

    // cs_n idles high in the synchronizer so reset never looks like a select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sck_d     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_d      <= cs_s;
            sck_d     <= sck_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cs_s) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:  if (cs_fall) state_next = CMD;
                CMD:   if (byte_done) begin
                           case (rx_byte)
                               8'h0B, 8'h02: state_next = ADDR;
                               8'h05:        state_next = STAT;
                               default:      state_next = IGNORE;
                           endcase
                       end
                ADDR:  if (addr_done) state_next = (opcode == 8'h0B) ? DUMMY : WR;
                DUMMY: if (byte_done) state_next = RD;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_miso   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            err        <= 1'b0;
            cnt        <= '0;
            shreg      <= '0;
            opcode     <= '0;
            addr       <= '0;
            tx_sr      <= '0;
            cur_word   <= '0;
            pf_word    <= '0;
            want_fetch <= 1'b0;
            want_pf    <= 1'b0;
            want_addr  <= '0;
            req_pf     <= 1'b0;
            req_live   <= 1'b0;
        end else begin
            // A read belonging to an aborted transfer completes normally but its data is dropped
            if (mem_req) begin
                if (mem_valid) begin
                    mem_req <= 1'b0;
                    if (req_live && !mem_we) begin
                        if (req_pf) pf_word  <= mem_rdata;
                        else        cur_word <= mem_rdata;
                    end
                end
            end else if (want_fetch) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= want_addr;
                mem_be     <= '1;
                mem_wdata  <= '0;
                req_pf     <= want_pf;
                req_live   <= 1'b1;
                want_fetch <= 1'b0;
            end

            if (sck_rise) begin
                shreg <= rx_addr[22:0];
                cnt   <= last_rise ? 5'd0 : cnt + 5'd1;
                case (state)
                    CMD:  if (byte_done) opcode <= rx_byte;
                    ADDR: if (addr_done) begin
                              addr <= rx_addr;
                              if (opcode == 8'h0B) begin
                                  want_fetch <= 1'b1;
                                  want_pf    <= 1'b0;
                                  want_addr  <= word_addr(rx_addr);
                              end
                          end
                    RD:   if (byte_done) begin
                              addr <= addr_inc;
                              if (addr[1:0] == 2'd3) cur_word <= pf_word;
                          end
                    WR:   if (byte_done) begin
                              if (mem_req) begin
                                  err <= 1'b1;
                              end else begin
                                  mem_req   <= 1'b1;
                                  mem_we    <= 1'b1;
                                  mem_addr  <= word_addr(addr);
                                  mem_be    <= 4'b0001 << addr[1:0];
                                  mem_wdata <= {4{rx_byte}};
                                  req_live  <= 1'b1;
                                  addr      <= addr_inc;
                              end
                          end
                    default: ;
                endcase
            end

            // Starting lane 3 prefetches the next word so the lane rollover has no bubble
            if (sck_fall && (state == RD || state == STAT)) begin
                if (cnt == 5'd0) begin
                    spi_miso <= load_byte[7];
                    tx_sr    <= {load_byte[6:0], 1'b0};
                    if (state == RD && addr[1:0] == 2'd3) begin
                        want_fetch <= 1'b1;
                        want_pf    <= 1'b1;
                        want_addr  <= word_addr(addr_inc);
                    end
                end else begin
                    spi_miso <= tx_sr[7];
                    tx_sr    <= {tx_sr[6:0], 1'b0};
                end
            end else if (state != RD && state != STAT) begin
                spi_miso <= 1'b0;
            end

            // An overrun stays flagged into the next select while its write is still in flight
            if (cs_rise) begin
                cnt        <= '0;
                spi_miso   <= 1'b0;
                want_fetch <= 1'b0;
                req_live   <= 1'b0;
            end else if (cs_fall) begin
                cnt <= '0;
                if (!mem_req) err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master tasks, latency-controlled memory model,
// and scoreboard queues for MISO bytes and memory requests.
module tb_spi_flash_responder;

    localparam logic [31:0] BASE = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_cs_n, spi_sck, spi_mosi, spi_miso;
    logic        mem_req, mem_we, mem_valid, busy, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int compared   = 0;
    int mismatched = 0;
    int mem_lat    = 3;

    logic [31:0] mem_model [logic [31:0]];
    logic [7:0]  exp_bytes [$];
    logic [68:0] exp_reqs  [$];
    logic [68:0] req_log   [$];

    spi_flash_responder #(.MEM_W(32), .ADDR_BASE(BASE), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [68:0] req_word(input logic we, input logic [3:0] be,
                                             input logic [31:0] a, input logic [31:0] d);
        return {we, be, a, d};
    endfunction

    // Memory model: logs each request, answers after mem_lat cycles with a one-cycle mem_valid
    initial begin
        logic [31:0] w;
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (mem_req && !rst) begin
                req_log.push_back(req_word(mem_we, mem_be, mem_addr, mem_we ? mem_wdata : 32'h0));
                repeat (mem_lat) @(negedge clk);
                w = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                    mem_model[mem_addr] = w;
                end else begin
                    mem_rdata = w;
                end
                mem_valid = 1'b1;
            end
        end
    end

    task automatic check_output(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sck_bit(input logic b, output logic r);
        spi_mosi = b;
        repeat (5) @(negedge clk);
        r = spi_miso;
        spi_sck = 1'b1;
        repeat (5) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) sck_bit(tx[i], rx[i]);
    endtask

    task automatic apply_stimulus(input logic [7:0] tx);
        logic [7:0] rx;
        spi_byte(tx, rx);
    endtask

    task automatic spi_bits(input logic [23:0] d, input int n);
        logic r;
        for (int i = n - 1; i >= 0; i--) sck_bit(d[i], r);
    endtask

    task automatic read_check(input string tag);
        logic [7:0] rx, expv;
        spi_byte(8'h00, rx);
        expv = exp_bytes.pop_front();
        check_output(tag, rx, expv);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (5) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_mem_idle(input string tag);
        int n;
        n = 0;
        while (mem_req && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_output({tag, " mem idle"}, mem_req, 1'b0);
    endtask

    task automatic check_requests(input string tag);
        int n;
        check_output({tag, " req count"}, req_log.size(), exp_reqs.size());
        n = (req_log.size() < exp_reqs.size()) ? req_log.size() : exp_reqs.size();
        for (int i = 0; i < n; i++)
            check_output($sformatf("%s req%0d", tag, i), req_log[i], exp_reqs[i]);
        req_log.delete();
        exp_reqs.delete();
    endtask

    initial begin
        rst = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        mem_model[BASE + 32'h100]       = 32'hDDCC_BBAA;
        mem_model[BASE + 32'h104]       = 32'h4433_2211;
        mem_model[BASE + 32'h00FF_FFFC] = 32'hA1B2_C3D4;
        mem_model[BASE]                 = 32'h0F1E_2D3C;

        repeat (4) @(negedge clk);
        check_output("reset miso", spi_miso, 1'b0);
        check_output("reset req", mem_req, 1'b0);
        check_output("reset busy", busy, 1'b0);
        check_output("reset err", err, 1'b0);
        check_output("reset addr", mem_addr, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] aligned read at 0x100");
        cs_low();
        apply_stimulus(8'h0B); apply_stimulus(8'h00); apply_stimulus(8'h01); apply_stimulus(8'h00);
        exp_reqs.push_back(req_word(1'b0, 4'hF, BASE + 32'h100, 32'h0));
        exp_reqs.push_back(req_word(1'b0, 4'hF, BASE + 32'h104, 32'h0));
        apply_stimulus(8'h00);
        exp_bytes.push_back(8'hAA); exp_bytes.push_back(8'hBB);
        exp_bytes.push_back(8'hCC); exp_bytes.push_back(8'hDD);
        for (int i = 0; i < 4; i++) read_check("rd_aligned byte");
        cs_high();
        wait_mem_idle("rd_aligned");
        check_requests("rd_aligned");

        $display("[TB] unaligned read at 0x102");
        cs_low();
        apply_stimulus(8'h0B); apply_stimulus(8'h00); apply_stimulus(8'h01); apply_stimulus(8'h02);
        exp_reqs.push_back(req_word(1'b0, 4'hF, BASE + 32'h100, 32'h0));
        exp_reqs.push_back(req_word(1'b0, 4'hF, BASE + 32'h104, 32'h0));
        apply_stimulus(8'h00);
        exp_bytes.push_back(8'hCC); exp_bytes.push_back(8'hDD);
        exp_bytes.push_back(8'h11); exp_bytes.push_back(8'h22);
        for (int i = 0; i < 4; i++) read_check("rd_unaligned byte");
        cs_high();
        wait_mem_idle("rd_unaligned");
        check_requests("rd_unaligned");

        $display("[TB] page program at 0xFE");
        cs_low();
        apply_stimulus(8'h02); apply_stimulus(8'h00); apply_stimulus(8'h00); apply_stimulus(8'hFE);
        exp_reqs.push_back(req_word(1'b1, 4'b0100, BASE + 32'hFC, 32'h5555_5555));
        exp_reqs.push_back(req_word(1'b1, 4'b1000, BASE + 32'hFC, 32'h6666_6666));
        exp_reqs.push_back(req_word(1'b1, 4'b0001, BASE + 32'h100, 32'h7777_7777));
        apply_stimulus(8'h55); apply_stimulus(8'h66); apply_stimulus(8'h77);
        cs_high();
        wait_mem_idle("pp");
        check_requests("pp");
        check_output("pp err", err, 1'b0);

        $display("[TB] write overrun");
        mem_lat = 300;
        cs_low();
        apply_stimulus(8'h02); apply_stimulus(8'h00); apply_stimulus(8'h02); apply_stimulus(8'h00);
        exp_reqs.push_back(req_word(1'b1, 4'b0001, BASE + 32'h200, 32'h0101_0101));
        apply_stimulus(8'h01); apply_stimulus(8'h02);
        repeat (5) @(negedge clk);
        check_output("ovr err", err, 1'b1);
        cs_high();
        cs_low();
        apply_stimulus(8'h05);
        exp_bytes.push_back(8'h03);
        read_check("ovr stat pending");
        cs_high();
        check_output("ovr err kept", err, 1'b1);
        wait_mem_idle("ovr");
        check_requests("ovr");
        mem_lat = 3;
        cs_low();
        apply_stimulus(8'h05);
        exp_bytes.push_back(8'h00);
        read_check("ovr stat cleared");
        check_output("ovr err cleared", err, 1'b0);
        cs_high();

        $display("[TB] abort during address");
        cs_low();
        apply_stimulus(8'h0B);
        spi_bits(24'h000ABC, 12);
        cs_high();
        check_output("abort addr req", mem_req, 1'b0);
        check_output("abort addr busy", busy, 1'b0);
        check_requests("abort addr");
        cs_low();
        apply_stimulus(8'h05);
        exp_bytes.push_back(8'h00);
        read_check("abort addr stat");
        cs_high();

        $display("[TB] abort during read with prefetch pending");
        mem_lat = 60;
        cs_low();
        apply_stimulus(8'h0B); apply_stimulus(8'h00); apply_stimulus(8'h01); apply_stimulus(8'h03);
        exp_reqs.push_back(req_word(1'b0, 4'hF, BASE + 32'h100, 32'h0));
        exp_reqs.push_back(req_word(1'b0, 4'hF, BASE + 32'h104, 32'h0));
        apply_stimulus(8'h00);
        spi_bits(24'h0, 4);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check_output("abort rd req held", mem_req, 1'b1);
        check_output("abort rd busy", busy, 1'b1);
        check_output("abort rd miso", spi_miso, 1'b0);
        wait_mem_idle("abort rd");
        check_output("abort rd busy done", busy, 1'b0);
        check_requests("abort rd");
        mem_lat = 3;

        $display("[TB] address wrap");
        cs_low();
        apply_stimulus(8'h0B); apply_stimulus(8'hFF); apply_stimulus(8'hFF); apply_stimulus(8'hFF);
        exp_reqs.push_back(req_word(1'b0, 4'hF, BASE + 32'h00FF_FFFC, 32'h0));
        exp_reqs.push_back(req_word(1'b0, 4'hF, BASE, 32'h0));
        apply_stimulus(8'h00);
        exp_bytes.push_back(8'hA1); exp_bytes.push_back(8'h3C);
        read_check("wrap byte");
        read_check("wrap byte");
        cs_high();
        wait_mem_idle("wrap");
        check_requests("wrap");

        $display("[TB] reset mid-transfer");
        mem_lat = 300;
        cs_low();
        apply_stimulus(8'h0B); apply_stimulus(8'h00); apply_stimulus(8'h01); apply_stimulus(8'h04);
        spi_bits(24'h0, 4);
        check_output("pre-reset req", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_output("async rst req", mem_req, 1'b0);
        check_output("async rst addr", mem_addr, 32'h0);
        check_output("async rst be", mem_be, 4'h0);
        check_output("async rst miso", spi_miso, 1'b0);
        check_output("async rst busy", busy, 1'b0);
        check_output("async rst err", err, 1'b0);
        spi_cs_n = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
